// File: rtl/painel_chamadas.sv
// Elevator call panel: synchronizes, debounces and latches active-low floor buttons, then picks a target floor.
// Press-to-req latency is DEBOUNCE_CYCLES+3 cycles, scheduler outputs follow req by one cycle; there is no backpressure.
module painel_chamadas #(
  parameter int NUM_ANDARES     = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ANDARES-1:0] btn_n,
  input  logic [2:0]             andar_atual,
  input  logic                   motor_up,
  input  logic                   motor_down,
  output logic [NUM_ANDARES-1:0] req,
  output logic [2:0]             andar_requisitado,
  output logic                   req_valid,
  output logic [1:0]             sentido
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SUBINDO  = 2'b01,
    DESCENDO = 2'b10
  } estado_t;

  logic [NUM_ANDARES-1:0] sync1;
  logic [NUM_ANDARES-1:0] sync2;
  logic [NUM_ANDARES-1:0] deb;
  logic [NUM_ANDARES-1:0] deb_d;
  logic [CW-1:0]          cnt [NUM_ANDARES];

  logic [NUM_ANDARES-1:0] press;
  logic [NUM_ANDARES-1:0] clr_mask;
  logic [NUM_ANDARES-1:0] req_next;
  logic [31:0]            atual_ext;
  logic                   andar_valido;
  logic                   chegada;

  logic                   acima;
  logic                   abaixo;
  logic [2:0]             menor_acima;
  logic [2:0]             maior_abaixo;

  estado_t                estado;
  estado_t                estado_prox;
  logic [2:0]             alvo_prox;

  // Levels reset to 1 (released) so a button held through reset never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      for (int i = 0; i < NUM_ANDARES; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NUM_ANDARES; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press        = deb_d & ~deb;
  assign atual_ext    = 32'(andar_atual);
  assign andar_valido = atual_ext < 32'(NUM_ANDARES);
  assign chegada      = andar_valido && !motor_up && !motor_down;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_ANDARES; i++) begin
      clr_mask[i] = chegada && (atual_ext == 32'(i));
    end
  end

  // Clear is applied after the set, so arrival beats a press on the same floor.
  assign req_next = (req | press) & ~clr_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      req       <= '0;
      req_valid <= 1'b0;
    end else begin
      req       <= req_next;
      req_valid <= |req_next;
    end
  end

  always_comb begin
    acima        = 1'b0;
    abaixo       = 1'b0;
    menor_acima  = '0;
    maior_abaixo = '0;
    for (int i = NUM_ANDARES - 1; i >= 0; i--) begin
      if (req[i] && (32'(i) > atual_ext)) begin
        acima       = 1'b1;
        menor_acima = 3'(i);
      end
    end
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (req[i] && (32'(i) < atual_ext)) begin
        abaixo       = 1'b1;
        maior_abaixo = 3'(i);
      end
    end
  end

  always_comb begin
    estado_prox = estado;
    alvo_prox   = andar_requisitado;
    if (andar_valido) begin
      case (estado)
        IDLE:     estado_prox = acima  ? SUBINDO  : (abaixo ? DESCENDO : IDLE);
        SUBINDO:  estado_prox = acima  ? SUBINDO  : (abaixo ? DESCENDO : IDLE);
        DESCENDO: estado_prox = abaixo ? DESCENDO : (acima  ? SUBINDO  : IDLE);
        default:  estado_prox = IDLE;
      endcase
      // Target always matches the state being entered.
      case (estado_prox)
        SUBINDO:  alvo_prox = menor_acima;
        DESCENDO: alvo_prox = maior_abaixo;
        default:  alvo_prox = andar_atual;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado            <= IDLE;
      andar_requisitado <= '0;
    end else begin
      estado            <= estado_prox;
      andar_requisitado <= alvo_prox;
    end
  end

  assign sentido = 2'(estado);

endmodule

// File: tb/tb_painel_chamadas.sv
// Directed bench for painel_chamadas with NUM_ANDARES=5, DEBOUNCE_CYCLES=4.
module tb_painel_chamadas;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_n;
  logic [2:0] andar_atual;
  logic       motor_up;
  logic       motor_down;
  logic [4:0] req;
  logic [2:0] andar_requisitado;
  logic       req_valid;
  logic [1:0] sentido;

  int checks = 0;
  int errors = 0;
  int seen;

  painel_chamadas #(
    .NUM_ANDARES(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .andar_atual(andar_atual),
    .motor_up(motor_up),
    .motor_down(motor_down),
    .req(req),
    .andar_requisitado(andar_requisitado),
    .req_valid(req_valid),
    .sentido(sentido)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    btn_n       = 5'b11111;
    andar_atual = 3'd0;
    motor_up    = 1'b0;
    motor_down  = 1'b0;
    tick(2);
    chk("rst_req", 32'(req), 32'b00000);
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_target", 32'(andar_requisitado), 32'd0);
    chk("rst_sentido", 32'(sentido), 32'b00);
    reset = 1'b0;
    tick(1);

    // Floor 3 held 10 cycles from floor 0
    btn_n = 5'b10111;
    seen  = -1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (seen < 0 && req != 5'b00000) seen = i;
      if (seen >= 0 && i == seen + 1) begin
        chk("t1_sentido", 32'(sentido), 32'b01);
        chk("t1_target", 32'(andar_requisitado), 32'd3);
      end
    end
    chk("t1_latency", 32'(seen >= 0 && seen <= 7), 32'd1);
    chk("t1_req", 32'(req), 32'b01000);
    chk("t1_valid", 32'(req_valid), 32'd1);
    btn_n = 5'b11111;
    tick(1);

    // Arrival at floor 3 clears the call
    andar_atual = 3'd3;
    tick(8);
    chk("t1c_req", 32'(req), 32'b00000);
    chk("t1c_valid", 32'(req_valid), 32'd0);
    chk("t1c_sentido", 32'(sentido), 32'b00);
    chk("t1c_target", 32'(andar_requisitado), 32'd3);

    // Bouncing floor 2, never 4 stable low samples
    btn_n = 5'b11011; tick(3);
    btn_n = 5'b11111; tick(1);
    btn_n = 5'b11011; tick(2);
    btn_n = 5'b11111; tick(1);
    btn_n = 5'b11011; tick(3);
    btn_n = 5'b11111; tick(10);
    chk("t2_req", 32'(req), 32'b00000);

    // Floors 1 and 4 pressed while moving up past floor 2
    andar_atual = 3'd2;
    motor_up    = 1'b1;
    tick(1);
    btn_n = 5'b01101;
    tick(10);
    btn_n = 5'b11111;
    tick(2);
    chk("t3_req", 32'(req), 32'b10010);
    chk("t3_sentido", 32'(sentido), 32'b01);
    chk("t3_target", 32'(andar_requisitado), 32'd4);
    andar_atual = 3'd4;
    motor_up    = 1'b0;
    tick(1);
    chk("t3a_req", 32'(req), 32'b00010);
    chk("t3a_sentido", 32'(sentido), 32'b10);
    chk("t3a_target", 32'(andar_requisitado), 32'd1);
    tick(1);
    chk("t3b_target", 32'(andar_requisitado), 32'd1);

    // Arrive at floor 1, then park moving at floor 0 with a call for floor 0
    andar_atual = 3'd1;
    tick(1);
    chk("t4_clear1", 32'(req), 32'b00000);
    andar_atual = 3'd0;
    motor_up    = 1'b1;
    tick(1);
    btn_n = 5'b11110;
    tick(10);
    btn_n = 5'b11111;
    tick(2);
    chk("t4_req", 32'(req), 32'b00001);
    chk("t4_sentido", 32'(sentido), 32'b00);
    chk("t4_target", 32'(andar_requisitado), 32'd0);

    // Invalid floor 6: no clear, scheduler held
    andar_atual = 3'd6;
    motor_up    = 1'b0;
    tick(3);
    chk("t4i_req", 32'(req), 32'b00001);
    chk("t4i_valid", 32'(req_valid), 32'd1);
    chk("t4i_sentido", 32'(sentido), 32'b00);
    chk("t4i_target", 32'(andar_requisitado), 32'd0);

    // Both motor bits set counts as moving
    andar_atual = 3'd0;
    motor_up    = 1'b1;
    motor_down  = 1'b1;
    tick(2);
    chk("t4m_req", 32'(req), 32'b00001);
    motor_up   = 1'b0;
    motor_down = 1'b0;
    tick(1);
    chk("t4s_req", 32'(req), 32'b00000);
    chk("t4s_valid", 32'(req_valid), 32'd0);

    // Floors 2 and 4 pressed while stopped at floor 2: clear wins on 2 only
    andar_atual = 3'd2;
    tick(1);
    btn_n = 5'b01011;
    tick(10);
    btn_n = 5'b11111;
    tick(2);
    chk("t5_req", 32'(req), 32'b10000);
    chk("t5_sentido", 32'(sentido), 32'b01);
    chk("t5_target", 32'(andar_requisitado), 32'd4);

    // Reset two cycles into a floor-1 press, button kept held
    btn_n = 5'b11101;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_req", 32'(req), 32'b00000);
    chk("t6_rst_valid", 32'(req_valid), 32'd0);
    chk("t6_rst_sentido", 32'(sentido), 32'b00);
    chk("t6_rst_target", 32'(andar_requisitado), 32'd0);
    reset = 1'b0;
    tick(5);
    chk("t6_early", 32'(req), 32'b00000);
    tick(5);
    chk("t6_req", 32'(req), 32'b00010);
    chk("t6_sentido", 32'(sentido), 32'b10);
    chk("t6_target", 32'(andar_requisitado), 32'd1);
    btn_n = 5'b11111;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/painel_chamadas.md
PAINEL_CHAMADAS -- requirements
Module: painel_chamadas

Interface
REQ-001 SHALL have parameter NUM_ANDARES, default 5, meaning the number of floors served; floor index range is 0..NUM_ANDARES-1.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the number of consecutive stable samples a button needs (20 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_n  input  NUM_ANDARES  raw call buttons, active low and asynchronous to clk; bit i is floor i.
REQ-006 SHALL have port andar_atual  input  3  current cabin floor reported by the elevator controller.
REQ-007 SHALL have port motor_up  input  1  cabin moving up.
REQ-008 SHALL have port motor_down  input  1  cabin moving down.
REQ-009 SHALL have port req  output  NUM_ANDARES  registered pending-call vector; bit i=1 means a call to floor i is outstanding.
REQ-010 SHALL have port andar_requisitado  output  3  registered target floor chosen by the scheduler.
REQ-011 SHALL have port req_valid  output  1  registered; 1 when req is nonzero.
REQ-012 SHALL have port sentido  output  2  registered scheduler state: 00 IDLE, 01 SUBINDO, 10 DESCENDO.

Function
REQ-013 SHALL pass each btn_n bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce each synchronized bit independently with its own counter of width $clog2(DEBOUNCE_CYCLES+1): the debounced level changes only after the synchronized bit has differed from it for DEBOUNCE_CYCLES consecutive cycles; any sample that equals the current level clears the counter.
REQ-015 SHALL set req[i] on the cycle after debounced bit i goes 1->0, provided no clear applies; release (0->1) SHALL have no effect.
REQ-016 SHALL set req[i] no later than DEBOUNCE_CYCLES+4 cycles after btn_n[i] falls and stays low; a low pulse shorter than DEBOUNCE_CYCLES cycles SHALL never set req[i].
REQ-017 SHALL define arrival as andar_atual<NUM_ANDARES with motor_up=0 and motor_down=0; on each arrival cycle, req[andar_atual] SHALL be 0 on the next cycle.
REQ-018 SHALL ignore a press when it coincides with arrival at the same floor (clear wins); presses on other floors in the same cycle SHALL still latch.
REQ-019 SHALL treat andar_atual>=NUM_ANDARES as invalid: no clear, scheduler state and outputs held.
REQ-020 SHALL treat motor_up=motor_down=1 as moving (no clear).
REQ-021 SHALL run a 3-state scheduler FSM (IDLE, SUBINDO, DESCENDO), with state and targets computed from the current registered req and andar_atual.
REQ-022 IDLE: if any pending floor is above andar_atual -> SUBINDO, else if any is below -> DESCENDO, else stay; a pending request at andar_atual alone SHALL keep IDLE.
REQ-023 SUBINDO: andar_requisitado = lowest pending floor > andar_atual; if none exists -> DESCENDO when any pending floor is below, else -> IDLE.
REQ-024 DESCENDO: andar_requisitado = highest pending floor < andar_atual; if none exists -> SUBINDO when any pending floor is above, else -> IDLE.
REQ-025 SHALL hold andar_requisitado = andar_atual while IDLE.
REQ-026 SHALL update andar_requisitado and sentido one cycle after the req/andar_atual change that causes them (registered, 1-cycle latency).
REQ-027 SHALL set req_valid = |req, registered in the same cycle as req.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, force req=0, req_valid=0, andar_requisitado=0, sentido=IDLE, all debounce counters=0, and all synchronizer and debounced levels=1 (released).
REQ-029 SHALL discard any press in progress when reset is asserted mid-debounce; the button must then be re-held for the full DEBOUNCE_CYCLES after reset falls.

Verification (DEBOUNCE_CYCLES=4, NUM_ANDARES=5)
REQ-030 SHALL check: reset, then btn_n[3] low for 10 cycles, andar_atual=0, motors 0 -> req=01000 within 8 cycles, req_valid=1, sentido=SUBINDO, andar_requisitado=3 one cycle later.
REQ-031 SHALL check: btn_n[2] low for 3 cycles, bouncing, then high -> req stays 00000.
REQ-032 SHALL check: req=10010, andar_atual=2, sentido=SUBINDO -> target 4; then andar_atual=4 with motors 0 -> req=00010, sentido=DESCENDO, target 1.
REQ-033 SHALL check: press floor 2 completing on the same cycle as arrival at floor 2 with motors 0 -> req[2]=0.
REQ-034 SHALL check: andar_atual=6 while req=00001 -> no clear; sentido and target unchanged.
REQ-035 SHALL check: reset asserted 2 cycles into a floor-1 press -> req=00000; after release of reset, a 10-cycle hold sets req[1].
